pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measures an incoming PWM waveform. Reports the high time and the period, both in clk_sys_i cycles.
- Complements the existing PWM generator. Used to read back PWM outputs, for example fan tachometers or loopback self-test of generated PWM lines.
- Sits on the system clock. pwm_i is treated as asynchronous and is synchronised internally.
- Results are held in output registers and flagged by a one-cycle valid strobe.

Parameters:
- CtrSize, 10, width of the high-time and period counters and result outputs. The maximum measurable value is 2^CtrSize-1.

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_i  input  1  synchronous, active-high reset.
- enable_i  input  1  capture enable. When low, the block is held idle.
- pwm_i  input  1  asynchronous PWM input.
- valid_o  output  1  one-cycle strobe; results updated this cycle.
- high_width_o  output  CtrSize  cycles pwm was high in the last measured period.
- period_o  output  CtrSize  cycles from rising edge to next rising edge.
- overflow_o  output  1  last result saturated (no rising edge within 2^CtrSize-1 cycles).

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-high, sampled on the clk_sys_i rising edge.
  - Reset values: valid_o=0, high_width_o=0, period_o=0, overflow_o=0, all counters 0, sync flops 0, state WAIT_LOW.
  - Reset asserted mid-measurement discards everything and returns to the reset values on the next edge.
- Synchronisation:
  - pwm_i passes through 2 flops (s1, s2), then a third flop s3 for edge detect.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - A pwm_i transition first sampled at edge k produces rise/fall during the cycle after edge k+1. This is a fixed 2-cycle latency, identical for both edges, so widths are unaffected.
- State machine (states WAIT_LOW, WAIT_RISE, MEAS_HIGH, MEAS_LOW):
  - WAIT_LOW: wait for s2==0, then go to WAIT_RISE. This discards a partial pulse present at reset or enable.
  - WAIT_RISE: on rise, hc=1, pc=1, go to MEAS_HIGH.
  - MEAS_HIGH: each cycle without fall, hc++ and pc++. On fall, pc++, hc holds, go to MEAS_LOW.
  - MEAS_LOW: each cycle without rise, pc++. On rise, capture (see below), reload hc=1 and pc=1, go to MEAS_HIGH.
- Capture:
  - On the edge following the capture cycle: high_width_o=hc, period_o=pc, overflow_o=0, valid_o=1 for exactly one cycle.
  - The outputs hold until the next capture.
  - Result: high H cycles and low L cycles gives high_width_o=H, period_o=H+L.
- Saturation:
  - In MEAS_HIGH or MEAS_LOW, if pc==2^CtrSize-1 and no rise in this cycle, emit a result with period_o=2^CtrSize-1, high_width_o=hc, overflow_o=1, valid_o=1.
  - Then go to WAIT_LOW. A stuck-high line therefore waits for a low before re-arming.
  - hc never exceeds pc. Counters never wrap.
- enable_i:
  - While enable_i=0: state is forced to WAIT_LOW, counters are cleared, no valid_o. Outputs other than valid_o hold their last values.
  - The sync flops keep running.
  - enable_i dropping mid-measurement aborts that measurement with no result.
- Simultaneous events:
  - rise and fall cannot coexist in one cycle.
  - Saturation and rise in the same cycle: rise wins and the capture is normal with pc=2^CtrSize-1 and overflow_o=0.
- A 1-cycle-wide synchronised high pulse is valid and gives high_width_o=1.
- Minimum measurable period is 2.

Test Plan:
- CtrSize=10, drive pwm_i from an 8-bit PWM generator with pulse_width=64 (high 64, low 192 cycles):
  - The first valid_o appears after the first complete period following reset.
  - Expect high_width_o=64, period_o=256, overflow_o=0 every 256 cycles, valid_o high exactly 1 cycle each.
- pwm_i high when reset is released, falling after 30 cycles, then square wave of 10 high / 10 low:
  - The partial pulse is ignored.
  - First result is high_width_o=10, period_o=20.
- pwm_i constant 0 for 5000 cycles → valid_o never asserts and outputs stay at 0.
- pwm_i rises once then stays high:
  - Expect valid_o with overflow_o=1, period_o=1023, high_width_o=1023.
  - No further valid_o until pwm_i goes low and rises again.
- Square wave of 1 high / 1 low → high_width_o=1, period_o=2 on every rising edge.
- Mid-period events:
  - Assert rst_sys_i for 1 cycle mid-period → all outputs are 0 the next cycle, and the next result is from a full clean period.
  - Repeat with enable_i low for 3 cycles mid-period → no result for the aborted period, and outputs hold their prior values.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in clk_sys_i cycles.
// Rev 1.0 - initial release.
`default_nettype none

module pwm_capture #(
  parameter int CtrSize = 10
) (
  input  logic               clk_sys_i,
  input  logic               rst_sys_i,
  input  logic               enable_i,
  input  logic               pwm_i,
  output logic               valid_o,
  output logic [CtrSize-1:0] high_width_o,
  output logic [CtrSize-1:0] period_o,
  output logic               overflow_o
);

  localparam logic [CtrSize-1:0] CTR_MAX = '1;
  localparam logic [CtrSize-1:0] CTR_ONE = CtrSize'(1);

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]         prime_q, prime_d;
  logic [CtrSize-1:0] hc_q, hc_d, pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [CtrSize-1:0] high_q, high_d, period_q, period_d;
  logic               ovf_q, ovf_d;
  logic               rise, fall, primed, saturate;

  assign rise   = s2_q & ~s3_q;
  assign fall   = ~s2_q & s3_q;
  // Reset zeroes the sync chain, so s2 only reflects pwm_i again two edges
  // later; arming before then would mistake a pulse held across reset for a rise.
  assign primed = prime_q[1];

  always_comb begin
    s1_d     = pwm_i;
    s2_d     = s1_q;
    s3_d     = s2_q;
    prime_d  = {prime_q[0], 1'b1};
    state_d  = state_q;
    hc_d     = hc_q;
    pc_d     = pc_q;
    valid_d  = 1'b0;
    high_d   = high_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    saturate = 1'b0;

    if (!enable_i) begin
      state_d = WAIT_LOW;
      hc_d    = '0;
      pc_d    = '0;
    end else begin
      case (state_q)
        WAIT_LOW: begin
          if (primed && !s2_q) state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            hc_d    = CTR_ONE;
            pc_d    = CTR_ONE;
            state_d = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (pc_q == CTR_MAX) begin
            saturate = 1'b1;
          end else if (fall) begin
            pc_d    = pc_q + CTR_ONE;
            state_d = MEAS_LOW;
          end else begin
            hc_d = hc_q + CTR_ONE;
            pc_d = pc_q + CTR_ONE;
          end
        end
        MEAS_LOW: begin
          // A rise on the saturating cycle still completes a normal period.
          if (rise) begin
            valid_d  = 1'b1;
            high_d   = hc_q;
            period_d = pc_q;
            ovf_d    = 1'b0;
            hc_d     = CTR_ONE;
            pc_d     = CTR_ONE;
            state_d  = MEAS_HIGH;
          end else if (pc_q == CTR_MAX) begin
            saturate = 1'b1;
          end else begin
            pc_d = pc_q + CTR_ONE;
          end
        end
        default: state_d = WAIT_LOW;
      endcase

      if (saturate) begin
        valid_d  = 1'b1;
        high_d   = hc_q;
        period_d = CTR_MAX;
        ovf_d    = 1'b1;
        hc_d     = '0;
        pc_d     = '0;
        state_d  = WAIT_LOW;
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      prime_q  <= 2'b00;
      state_q  <= WAIT_LOW;
      hc_q     <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      high_q   <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      prime_q  <= prime_d;
      state_q  <= state_d;
      hc_q     <= hc_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      high_q   <= high_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
    end
  end

  assign valid_o      = valid_q;
  assign high_width_o = high_q;
  assign period_o     = period_q;
  assign overflow_o   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture with CtrSize=10.
// Rev 1.0 - initial release.
`default_nettype none

module tb_pwm_capture;

  localparam int CTR = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b1;
  logic           pwm = 1'b0;
  logic           valid;
  logic [CTR-1:0] hw;
  logic [CTR-1:0] per;
  logic           ovf;

  typedef struct {
    int hw;
    int per;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pwm_capture #(.CtrSize(CTR)) dut (
    .clk_sys_i    (clk),
    .rst_sys_i    (rst),
    .enable_i     (en),
    .pwm_i        (pwm),
    .valid_o      (valid),
    .high_width_o (hw),
    .period_o     (per),
    .overflow_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int h, input int p, input int o);
    exp_t e;
    e.hw  = h;
    e.per = p;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic level, input int n);
    pwm = level;
    rst = 1'b1;
    wait_cyc(n);
    rst = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int h, input int p, input int o);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_high"}, int'(hw), h);
    check({tag, "_period"}, int'(per), p);
    check({tag, "_ovf"}, int'(ovf), o);
  endtask

  // n full periods plus the closing rise, each completed period queued as a result
  task automatic square(input int h, input int l, input int n);
    for (int i = 0; i <= n; i++) begin
      pwm = 1'b1;
      if (i > 0) push(h, h + l, 0);
      wait_cyc(h);
      if (i < n) begin
        pwm = 1'b0;
        wait_cyc(l);
      end
    end
    wait_cyc(8);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_high", int'(hw), e.hw);
        check("res_period", int'(per), e.per);
        check("res_ovf", int'(ovf), e.ovf);
      end
    end
  end

  initial begin
    // Reset state, then 64/192 PWM
    do_reset(1'b0, 3);
    check_outs("reset", 0, 0, 0);
    wait_cyc(5);
    square(64, 192, 4);

    // Pulse already high at reset release is discarded
    do_reset(1'b1, 3);
    wait_cyc(30);
    pwm = 1'b0;
    wait_cyc(10);
    square(10, 10, 3);

    // Idle line produces nothing
    do_reset(1'b0, 3);
    wait_cyc(5000);
    check_outs("idle", 0, 0, 0);

    // Stuck high saturates once, then re-arms only after a low
    do_reset(1'b0, 3);
    wait_cyc(5);
    pwm = 1'b1;
    push(1023, 1023, 1);
    wait_cyc(1100);
    check_outs("stuck", 1023, 1023, 1);
    pwm = 1'b0;
    wait_cyc(10);
    square(10, 10, 1);

    // Minimum period
    do_reset(1'b0, 3);
    wait_cyc(5);
    square(1, 1, 6);

    // One-cycle reset mid-period
    do_reset(1'b0, 3);
    wait_cyc(5);
    square(10, 10, 2);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check_outs("midrst", 0, 0, 0);
    wait_cyc(5);
    pwm = 1'b0;
    wait_cyc(10);
    square(12, 8, 2);

    // Enable low for 3 cycles mid-period aborts without touching outputs
    wait_cyc(3);
    en = 1'b0;
    wait_cyc(3);
    en = 1'b1;
    check_outs("midenable", 12, 20, 0);
    wait_cyc(5);
    pwm = 1'b0;
    wait_cyc(10);
    square(14, 6, 2);

    wait_cyc(5);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
